// File: rtl/gc_stream_sequencer_if.sv
// Output stream of the garbling sequencer: FIFO head plus sink handshake.
interface gc_stream_sequencer_if #(
  parameter int S = 32,
  parameter int K = 128
);
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_tag;
  logic [S-1:0] out_cid;
  logic [S-1:0] out_index;
  logic [K-1:0] out_data;

  modport master (output out_valid, out_tag, out_cid, out_index, out_data, input out_ready);
  modport slave  (input out_valid, out_tag, out_cid, out_index, out_data, output out_ready);
endinterface

// File: rtl/gc_stream_sequencer.sv
// Runs one GarbledCircuit pass per go, queues tagged output words in a FIFO
// and streams them to a sink; words that do not fit are dropped, never stalled.
module gc_stream_sequencer #(
  parameter int S     = 32,
  parameter int K     = 128,
  parameter int CC    = 1,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  output logic                  gc_start,
  input  logic [2:0]            tag_t1,
  input  logic [S-1:0]          cid,
  input  logic [S-1:0]          index0_t1,
  input  logic [S-1:0]          index1_t1,
  input  logic [K-1:0]          data0_t1,
  input  logic [K-1:0]          data1_t1,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [31:0]           run_cycles,
  gc_stream_sequencer_if.master out
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [2:0]   tag;
    logic [S-1:0] cid;
    logic [S-1:0] index;
    logic [K-1:0] data;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   run_q, run_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  entry_t        mem [DEPTH];

  logic [AW:0]   count;
  logic [AW+1:0] free;
  logic          empty, pop, cap, want0, want1, push0, push1, drop;
  logic [AW-1:0] wa0, wa1;
  entry_t        w0, w1, first, head;

  assign count = wr_q - rd_q;
  assign empty = (count == '0);
  assign pop   = ~empty & out.out_ready;
  // Free space counts the slot released by a pop in the same cycle.
  assign free  = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);

  assign cap   = (state_q == RUN) && (cid != S'(CC));
  assign want0 = tag_t1[2] ? tag_t1[0] : (tag_t1 != 3'b000);
  assign want1 = tag_t1[2] ? tag_t1[1] : (tag_t1 == 3'b001 || tag_t1 == 3'b010);
  assign push0 = cap && (want0 || want1) && (free != '0);
  assign push1 = cap && want0 && want1 && (free >= (AW+2)'(2));
  assign drop  = cap && (((want0 || want1) && !push0) || (want0 && want1 && !push1));

  assign w0    = {tag_t1, cid, index0_t1, data0_t1};
  assign w1    = {tag_t1, cid, index1_t1, data1_t1};
  assign first = want0 ? w0 : w1;
  assign wa0   = wr_q[AW-1:0];
  assign wa1   = wa0 + AW'(1);
  assign wr_d  = wr_q + (AW+1)'(push0) + (AW+1)'(push1);
  assign rd_d  = rd_q + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push0) mem[wa0] <= first;
    if (push1) mem[wa1] <= w1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    ovf_d    = ovf_q | drop;
    gc_start = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE:  if (go) state_d = START;
      START: begin
        gc_start = 1'b1;
        run_d    = '0;
        ovf_d    = 1'b0;
        state_d  = RUN;
      end
      RUN: begin
        if (cid == S'(CC)) state_d = DRAIN;
        else if (run_q != 32'hFFFF_FFFF) run_d = run_q + 32'd1;
      end
      DRAIN: if (empty) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign overflow   = ovf_q;
  assign run_cycles = run_q;

  // Head fields read as zero whenever the FIFO is empty, including during reset.
  assign head          = mem[rd_q[AW-1:0]];
  assign out.out_valid = ~empty;
  assign out.out_tag   = empty ? '0 : head.tag;
  assign out.out_cid   = empty ? '0 : head.cid;
  assign out.out_index = empty ? '0 : head.index;
  assign out.out_data  = empty ? '0 : head.data;
endmodule
